// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface inst_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, in-order response buffer, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN adds the fetch_misalign port and a HALT state.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_unit_if.master  bus,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [31:0]        out_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic               fetch_misalign
`endif
);

  localparam int unsigned PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    S_HALT
`endif
  } state_t;

  state_t        state, state_n;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding, drop_cnt, count, flight_after;
  logic [31:0]   buf_inst [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [31:0]   pcq      [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, pq_rd, pq_wr;
  logic          req_fire, rsp_keep, rsp_drop, pop;
  logic [31:0]   target;

  assign target = redirect_target & 32'hFFFF_FFFC;

  assign bus.imem_req_valid = (state == S_RUN) && ((outstanding + count) < DEPTH_C);
  assign bus.imem_req_addr  = pc;

  assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_drop = bus.imem_rsp_valid & (drop_cnt != '0);
  assign rsp_keep = bus.imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign pop      = out_valid & out_ready;

  assign out_valid = (count != '0);
  assign out_inst  = buf_inst[rd_ptr];
  assign out_pc    = buf_pc[rd_ptr];

  // Everything still owed by memory once this cycle settles; becomes the discard count on redirect.
  assign flight_after = outstanding + drop_cnt + (req_fire ? C_ONE : '0)
                      - (bus.imem_rsp_valid ? C_ONE : '0);

  always_comb begin
    state_n = state;
    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_target[1:0] != 2'b00) state_n = S_HALT;
      else
`endif
      state_n = (flight_after != '0) ? S_DRAIN : S_RUN;
    end else begin
      case (state)
        S_IDLE:  state_n = S_RUN;
        S_DRAIN: if (drop_cnt == '0 || (rsp_drop && drop_cnt == C_ONE)) state_n = S_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
        pcq[i]      <= '0;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (redirect_valid) begin
        pc          <= target;
        outstanding <= '0;
        drop_cnt    <= flight_after;
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        pq_rd       <= '0;
        pq_wr       <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_misalign <= (redirect_target[1:0] != 2'b00);
`endif
      end else begin
        if (req_fire) begin
          pcq[pq_wr] <= pc;
          pq_wr      <= pq_wr + P_ONE;
          pc         <= pc + 32'd4;
        end
        if (rsp_keep) begin
          buf_inst[wr_ptr] <= bus.imem_rsp_data;
          buf_pc[wr_ptr]   <= pcq[pq_rd];
          pq_rd            <= pq_rd + P_ONE;
          wr_ptr           <= wr_ptr + P_ONE;
        end
        if (rsp_drop) drop_cnt <= drop_cnt - C_ONE;
        if (pop) rd_ptr <= rd_ptr + P_ONE;
        outstanding <= outstanding + (req_fire ? C_ONE : '0) - (rsp_keep ? C_ONE : '0);
        count       <= count + (rsp_keep ? C_ONE : '0) - (pop ? C_ONE : '0);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: queue-based fetch model plus directed scenarios.
module tb_inst_fetch_unit;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst, out_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  inst_fetch_unit_if bus();

  inst_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  int n_acc = 0;
  bit chk_en = 0;

  // memory: accepted addresses waiting for their response slot
  logic [31:0] mq[$];
  int          mdue[$];

  // model state
  int          m_phase;     // 0 idle, 1 run, 2 drain, 3 halt
  logic [31:0] m_pc;
  logic [31:0] m_fl[$];     // pcs of in-flight requests whose data will be kept
  int          m_drop;
  logic [31:0] m_bi[$], m_bp[$];
  bit          m_mis;
  logic [31:0] c_pc[$];     // instructions handed to decode, and when
  int          c_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit model_req();
    return (m_phase == 1) && ((m_fl.size() + m_bp.size()) < DEPTH);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = RPC; m_drop = 0; m_mis = 0;
    m_fl.delete(); m_bi.delete(); m_bp.delete();
  endtask

  task automatic model_update();
    bit req, acc, rsp, pop, mis;
    int fl;
    req = model_req();
    acc = req && bus.imem_req_ready;
    rsp = bus.imem_rsp_valid;
    pop = (m_bp.size() > 0) && out_ready;
    if (pop) begin c_pc.push_back(m_bp[0]); c_cyc.push_back(cyc); end
    if (redirect_valid) begin
      fl = m_fl.size() + m_drop + int'(acc) - int'(rsp);
      m_fl.delete(); m_bi.delete(); m_bp.delete();
      m_drop = fl;
      m_pc = redirect_target & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis = (redirect_target[1:0] != 2'b00);
`else
      mis = 0;
`endif
      m_mis = mis;
      m_phase = mis ? 3 : ((fl > 0) ? 2 : 1);
    end else begin
      if (pop) begin void'(m_bi.pop_front()); void'(m_bp.pop_front()); end
      if (rsp) begin
        if (m_drop > 0) m_drop--;
        else if (m_fl.size() > 0) begin
          m_bp.push_back(m_fl[0]);
          m_bi.push_back(mem_word(m_fl[0]));
          void'(m_fl.pop_front());
        end
      end
      if (acc) begin m_fl.push_back(m_pc); m_pc = m_pc + 32'd4; end
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 2 && m_drop == 0) m_phase = 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, model_req()});
      chk("req_addr", bus.imem_req_addr, m_pc);
      chk("out_valid", {31'b0, out_valid}, {31'b0, (m_bp.size() > 0)});
      if (m_bp.size() > 0) begin
        chk("out_inst", out_inst, m_bi[0]);
        chk("out_pc", out_pc, m_bp[0]);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
`endif
    end
  end

  task automatic step();
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      mq.push_back(bus.imem_req_addr);
      mdue.push_back(cyc + lat);
      n_acc++;
    end
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (mq.size() > 0 && mdue[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0]);
      void'(mq.pop_front());
      void'(mdue.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    chk_en = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    #1;
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, RPC);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    mq.delete(); mdue.delete();
    model_reset();
    c_pc.delete(); c_cyc.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
    n_acc = 0;
    chk_en = 1;
  endtask

  task automatic check_log(input int idx, input logic [31:0] epc, input int ecyc);
    if (idx < c_pc.size()) begin
      chk("log_pc", c_pc[idx], epc);
      if (ecyc >= 0) chk("log_cycle", c_cyc[idx], ecyc);
    end else begin
      chk("log_len", c_pc.size(), idx + 1);
    end
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    #3;

    // streaming: first delivery in cycle 3; two-entry credit gives a bubble every third cycle
    do_reset();
    lat = 1; bus.imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (14) step();
    chk("run_pops", c_pc.size(), 8);
    check_log(0, 32'h0, 3);
    check_log(1, 32'h4, 4);
    check_log(2, 32'h8, 6);
    check_log(3, 32'hC, 7);

    // decode stalled: exactly DEPTH requests, head held
    do_reset();
    out_ready = 1'b0;
    repeat (12) step();
    chk("stall_acc", n_acc, DEPTH);
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_pc", out_pc, 32'h0);
    chk("stall_inst", out_inst, mem_word(32'h0));
    out_ready = 1'b1;
    c_pc.delete(); c_cyc.delete();
    repeat (8) step();
    check_log(0, 32'h0, -1);
    check_log(1, 32'h4, -1);
    check_log(2, 32'h8, -1);

    // redirect with two requests in flight
    do_reset();
    lat = 3;
    repeat (3) step();
    chk("pre_redirect_inflight", n_acc, 2);
    redirect_valid = 1'b1; redirect_target = 32'h100;
    c_pc.delete(); c_cyc.delete();
    repeat (10) step();
    check_log(0, 32'h100, 10);

    // redirect coinciding with a response and a decode handshake
    do_reset();
    lat = 1;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_target = 32'h40;
    c_pc.delete(); c_cyc.delete();
    repeat (6) step();
    chk("coinc_pops", c_pc.size(), 3);
    check_log(0, 32'h0, 3);
    check_log(1, 32'h40, 6);
    check_log(2, 32'h44, 7);

    // memory not ready: address held, pc not advanced
    do_reset();
    bus.imem_req_ready = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'b0, bus.imem_req_valid}, 32'd1);
      chk("hold_addr", bus.imem_req_addr, 32'h0);
      step();
    end
    bus.imem_req_ready = 1'b1;
    c_pc.delete(); c_cyc.delete();
    repeat (5) step();
    check_log(0, 32'h0, 9);
    check_log(1, 32'h4, 10);

`ifdef FETCH_MISALIGN_TRAP_EN
    do_reset();
    lat = 2;
    repeat (4) step();
    redirect_valid = 1'b1; redirect_target = 32'h102;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("halt_flag", {31'b0, fetch_misalign}, 32'd1);
      chk("halt_noreq", {31'b0, bus.imem_req_valid}, 32'd0);
      step();
    end
    redirect_valid = 1'b1; redirect_target = 32'h200;
    c_pc.delete(); c_cyc.delete();
    repeat (10) step();
    chk("halt_clear", {31'b0, fetch_misalign}, 32'd0);
    check_log(0, 32'h200, -1);
`endif

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
